// File: rtl/cnna_udiv_35ns_8ns_27_seq.sv
// rtl/cnna_udiv_35ns_8ns_27_seq.sv - sequential restoring 35/8 unsigned divider, 27-bit quotient
module cnna_udiv_35ns_8ns_27_seq #(
  parameter int ID         = 32'd1,
  parameter int NUM_STAGE  = 32'd37,
  parameter int din0_WIDTH = 32'd35,
  parameter int din1_WIDTH = 32'd8,
  parameter int dout_WIDTH = 32'd27
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [7:0]            rem,
  output logic                  ovf,
  output logic                  dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  div;
  logic [8:0]  r;
  logic [34:0] d;
  logic [34:0] q;
  logic [5:0]  cnt;

  logic [8:0]  t;
  logic [8:0]  r_nxt;
  logic        q_bit;
  logic [34:0] q_nxt;

  // r stays below the divisor, so r[8] is never needed; q[34] shifts out unread.
  logic unused_bits;
  assign unused_bits = ^{ID, NUM_STAGE, r[8], q[34]};

  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);
  assign ap_ready = ap_start & ap_idle & ~ap_rst;

  // One restoring step: bring in the next dividend bit and try to subtract.
  always_comb begin
    t     = {r[7:0], d[34]};
    q_bit = (t >= {1'b0, div});
    r_nxt = q_bit ? (t - {1'b0, div}) : t;
    q_nxt = {q[33:0], q_bit};
  end

  // Control FSM, working registers and registered results.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      div   <= '0;
      r     <= '0;
      d     <= '0;
      q     <= '0;
      cnt   <= '0;
      dout  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            div <= din1;
            d   <= din0;
            r   <= '0;
            q   <= '0;
            cnt <= '0;
            if (din1 == 8'd0) begin
              // Divide by zero skips the iteration and reports saturated flags.
              state <= S_DONE;
              dout  <= '1;
              rem   <= '0;
              ovf   <= 1'b1;
              dbz   <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r   <= r_nxt;
          d   <= {d[33:0], 1'b0};
          q   <= q_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd34) begin
            // Last step: latch results straight from the final step's values.
            state <= S_DONE;
            dout  <= q_nxt[26:0];
            ovf   <= |q_nxt[34:27];
            rem   <= r_nxt[7:0];
            dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnna_udiv_35ns_8ns_27_seq.sv
// tb/tb_cnna_udiv_35ns_8ns_27_seq.sv - directed self-checking bench for the sequential divider
module tb_cnna_udiv_35ns_8ns_27_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [34:0] din0;
  logic [7:0]  din1;
  logic [26:0] dout;
  logic [7:0]  rem;
  logic        ovf;
  logic        dbz;

  int n_tests;
  int n_fail;

  cnna_udiv_35ns_8ns_27_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the churn test.
  task automatic model(input logic [34:0] a, input logic [7:0] b,
                       output logic [26:0] eq, output logic [7:0] er,
                       output logic eo, output logic ez);
    logic [63:0] qf;
    logic [63:0] rf;
    if (b == 8'd0) begin
      eq = 27'h7FFFFFF; er = 8'd0; eo = 1'b1; ez = 1'b1;
    end else begin
      qf = {29'd0, a} / {56'd0, b};
      rf = {29'd0, a} % {56'd0, b};
      eq = qf[26:0];
      er = rf[7:0];
      eo = (qf >= 64'd134217728);
      ez = 1'b0;
    end
  endtask

  // Start one divide from IDLE and check timing and results.
  task automatic run_div(input string tag, input logic [34:0] a, input logic [7:0] b,
                         input int exp_done_cyc, input logic [26:0] eq, input logic [7:0] er,
                         input logic eo, input logic ez);
    int done_cyc;
    int bad_idle;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; din0 = a; din1 = b;
    @(negedge ap_clk);
    check({tag, ".ready_c0"}, ap_ready, 1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0; din0 = '1; din1 = 8'hA5;
    done_cyc = -1;
    bad_idle = 0;
    for (int c = 1; c < 100; c++) begin
      @(negedge ap_clk);
      if (ap_idle) bad_idle++;
      if (ap_done) begin
        done_cyc = c;
        break;
      end
    end
    check({tag, ".done_cyc"}, done_cyc, exp_done_cyc);
    check({tag, ".idle_busy"}, bad_idle, 0);
    check({tag, ".dout"}, dout, eq);
    check({tag, ".rem"}, rem, er);
    check({tag, ".ovf"}, ovf, eo);
    check({tag, ".dbz"}, dbz, ez);
    @(negedge ap_clk);
    check({tag, ".idle_after"}, ap_idle, 1);
    check({tag, ".done_after"}, ap_done, 0);
  endtask

  initial begin
    int cap_cyc[4];
    int done_cyc_a[4];
    logic [26:0] xq[4];
    logic [7:0]  xr[4];
    logic        xo[4];
    logic        xz[4];
    int ncap;
    int ndone;
    int ndone_rst;

    n_tests = 0;
    n_fail  = 0;

    // Reset with ap_start high: reset must win.
    ap_rst = 1'b1; ap_start = 1'b1; din0 = 35'd5; din1 = 8'd0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst.ready", ap_ready, 0);
    check("rst.done", ap_done, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0; ap_start = 1'b0;
    @(negedge ap_clk);
    check("rst.idle", ap_idle, 1);
    check("rst.dout", dout, 0);
    check("rst.rem", rem, 0);
    check("rst.ovf", ovf, 0);
    check("rst.dbz", dbz, 0);

    run_div("basic",   35'd1000, 8'd7, 36, 27'd142, 8'd6, 1'b0, 1'b0);
    run_div("fit",     35'd134217727, 8'd1, 36, 27'h7FFFFFF, 8'd0, 1'b0, 1'b0);
    run_div("fit_ovf", 35'd134217728, 8'd1, 36, 27'd0, 8'd0, 1'b1, 1'b0);
    run_div("max",     35'h7FFFFFFFF, 8'd255, 36, 27'd526344, 8'd7, 1'b1, 1'b0);
    run_div("dbz",     35'd5, 8'd0, 1, 27'h7FFFFFF, 8'd0, 1'b1, 1'b1);
    run_div("post_dbz", 35'd100, 8'd9, 36, 27'd11, 8'd1, 1'b0, 1'b0);

    // Back-to-back with operand churn every cycle.
    ncap = 0;
    ndone = 0;
    for (int c = 0; c < 76; c++) begin
      @(posedge ap_clk); #1;
      ap_start = (c < 38);
      din0 = 35'(c * 123457 + 999);
      din1 = 8'(c * 37 + 3);
      @(negedge ap_clk);
      if (ap_ready) begin
        if (ncap < 4) begin
          cap_cyc[ncap] = c;
          model(din0, din1, xq[ncap], xr[ncap], xo[ncap], xz[ncap]);
        end
        ncap++;
      end
      if (ap_done) begin
        if (ndone < 4 && ndone < ncap) begin
          done_cyc_a[ndone] = c;
          check("churn.dout", dout, xq[ndone]);
          check("churn.rem", rem, xr[ndone]);
          check("churn.ovf", ovf, xo[ndone]);
          check("churn.dbz", dbz, xz[ndone]);
        end
        ndone++;
      end
    end
    ap_start = 1'b0;
    check("churn.ncap", ncap, 2);
    check("churn.ndone", ndone, 2);
    if (ncap >= 2) begin
      check("churn.cap0", cap_cyc[0], 0);
      check("churn.cap1", cap_cyc[1], 37);
    end
    if (ndone >= 2) begin
      check("churn.done0", done_cyc_a[0], 36);
      check("churn.done1", done_cyc_a[1], 73);
    end

    // Reset in cycle 10 of a 1000/7 divide.
    @(posedge ap_clk); #1;
    ap_start = 1'b1; din0 = 35'd1000; din1 = 8'd7;
    @(negedge ap_clk);
    check("rstmid.ready_c0", ap_ready, 1);
    ndone_rst = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      if (c == 10) ap_rst = 1'b1;
      @(negedge ap_clk);
      if (ap_done) ndone_rst++;
    end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rstmid.idle_c11", ap_idle, 1);
    check("rstmid.dout", dout, 0);
    check("rstmid.rem", rem, 0);
    check("rstmid.ovf", ovf, 0);
    check("rstmid.dbz", dbz, 0);
    for (int c = 12; c < 50; c++) begin
      @(negedge ap_clk);
      if (ap_done) ndone_rst++;
    end
    check("rstmid.no_done", ndone_rst, 0);

    run_div("after_rst", 35'd1000, 8'd7, 36, 27'd142, 8'd6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
